// File: rtl/xbar_stream_if.sv
// xbar_stream_if: stream, config and status signals of the xbar_stream crossbar.
// The master side produces input beats and config and consumes outputs; the crossbar is the slave.
interface xbar_stream_if #(
  parameter int ElemWidth = 8,
  parameter int NumIn     = 6,
  parameter int NumOut    = 6,
  parameter int SelWidth  = $clog2(NumIn)
);
  logic                                cfg_valid_i;
  logic [NumOut-1:0][SelWidth-1:0]     cfg_select_i;
  logic                                cfg_pending_o;
  logic [NumIn-1:0]                    in_valid_i;
  logic [NumIn-1:0][ElemWidth-1:0]     in_data_i;
  logic [NumIn-1:0]                    in_ready_o;
  logic [NumOut-1:0]                   out_valid_o;
  logic [NumOut-1:0][ElemWidth-1:0]    out_data_o;
  logic [NumOut-1:0]                   out_ready_i;
  logic [NumOut-1:0]                   sel_err_o;

  modport master (
    output cfg_valid_i, cfg_select_i, in_valid_i, in_data_i, out_ready_i,
    input  cfg_pending_o, in_ready_o, out_valid_o, out_data_o, sel_err_o
  );

  modport slave (
    input  cfg_valid_i, cfg_select_i, in_valid_i, in_data_i, out_ready_i,
    output cfg_pending_o, in_ready_o, out_valid_o, out_data_o, sel_err_o
  );
endinterface

// File: rtl/xbar_stream.sv
// xbar_stream: registered NumIn x NumOut valid/ready crossbar with a staged select table that commits once drained.
// Optional macro XBAR_SEL_WRAP_EN: out-of-range select entries wrap (sel - NumIn) instead of disabling the output.
module xbar_stream #(
  parameter int ElemWidth = 8,
  parameter int NumIn     = 6,
  parameter int NumOut    = 6,
  parameter int SelWidth  = $clog2(NumIn)
) (
  input logic          clk_i,
  input logic          rst_i,
  xbar_stream_if.slave bus
);
  localparam logic [0:0] IDLE    = 1'b0;
  localparam logic [0:0] PENDING = 1'b1;
  localparam logic [SelWidth:0] NUM_IN_W = NumIn[SelWidth:0];

  logic [0:0]                       state_q;
  logic [NumOut-1:0][SelWidth-1:0]  sel_q;
  logic [NumOut-1:0][SelWidth-1:0]  shadow_q;
  logic [NumOut-1:0][SelWidth-1:0]  src;
  logic [NumOut-1:0]                en;
  logic [NumOut-1:0]                can_acc;
  logic [NumOut-1:0]                load;
  logic [NumOut-1:0][ElemWidth-1:0] mux;
  logic [NumIn-1:0]                 has_lsn;
  logic [NumIn-1:0]                 lsn_ok;
  logic [NumIn-1:0]                 ready;
  logic [NumIn-1:0]                 fire;
  logic [NumOut-1:0]                out_valid_p1;
  logic [NumOut-1:0][ElemWidth-1:0] out_data_p1;

  function automatic logic sel_in_range(input logic [SelWidth-1:0] s);
    return {1'b0, s} < NUM_IN_W;
  endfunction

`ifdef XBAR_SEL_WRAP_EN
  function automatic logic [SelWidth-1:0] sel_wrap(input logic [SelWidth-1:0] s);
    logic [SelWidth:0] d;
    d = {1'b0, s} - NUM_IN_W;
    return d[SelWidth-1:0];
  endfunction
`endif

  always_comb begin
    src = sel_q;
    en  = '1;
    for (int j = 0; j < NumOut; j++) begin
      if (!sel_in_range(sel_q[j])) begin
`ifdef XBAR_SEL_WRAP_EN
        src[j] = sel_wrap(sel_q[j]);
`else
        src[j] = '0;
        en[j]  = 1'b0;
`endif
      end
    end
  end

  assign can_acc = ~out_valid_p1 | bus.out_ready_i;

  // An input is ready only if it has a listener and every listener can take the beat (all-or-nothing fork).
  always_comb begin
    has_lsn = '0;
    lsn_ok  = '1;
    for (int i = 0; i < NumIn; i++) begin
      for (int j = 0; j < NumOut; j++) begin
        if (en[j] && src[j] == SelWidth'(i)) begin
          has_lsn[i] = 1'b1;
          if (!can_acc[j]) lsn_ok[i] = 1'b0;
        end
      end
    end
  end

  assign ready = (state_q == IDLE) ? (has_lsn & lsn_ok) : '0;
  assign fire  = bus.in_valid_i & ready;

  always_comb begin
    load = '0;
    mux  = '0;
    for (int j = 0; j < NumOut; j++) begin
      for (int i = 0; i < NumIn; i++) begin
        if (src[j] == SelWidth'(i)) begin
          mux[j]  = bus.in_data_i[i];
          load[j] = en[j] && fire[i];
        end
      end
    end
  end

  // Stage p1: output slot registers and config state machine.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      out_valid_p1 <= '0;
      out_data_p1  <= '0;
      for (int j = 0; j < NumOut; j++) sel_q[j] <= SelWidth'(j % NumIn);
    end else begin
      for (int j = 0; j < NumOut; j++) begin
        if (load[j]) begin
          out_valid_p1[j] <= 1'b1;
          out_data_p1[j]  <= mux[j];
        end else if (bus.out_ready_i[j]) begin
          out_valid_p1[j] <= 1'b0;
        end
      end
      if (state_q == IDLE) begin
        if (bus.cfg_valid_i) begin
          shadow_q <= bus.cfg_select_i;
          state_q  <= PENDING;
        end
      end else if (&can_acc) begin
        sel_q   <= shadow_q;
        state_q <= IDLE;
      end
    end
  end

  assign bus.in_ready_o    = ready;
  assign bus.out_valid_o   = out_valid_p1;
  assign bus.out_data_o    = out_data_p1;
  assign bus.cfg_pending_o = (state_q == PENDING);
`ifdef XBAR_SEL_WRAP_EN
  assign bus.sel_err_o     = '0;
`else
  assign bus.sel_err_o     = ~en;
`endif
endmodule

// File: tb/tb_xbar_stream.sv
// tb_xbar_stream: directed stimulus with a per-output expected-data queue and an independent output monitor.
module tb_xbar_stream;
  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   tbl[6];
  int   mdl_sel[6];
  logic [7:0] exp_q[6][$];
  logic [7:0] mon_e;

  xbar_stream_if #(.ElemWidth(8), .NumIn(6), .NumOut(6)) bus ();

  xbar_stream #(.ElemWidth(8), .NumIn(6), .NumOut(6)) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus(bus)
  );

`ifdef XBAR_SEL_WRAP_EN
  localparam logic [63:0] ERR_T5   = 64'h00;
  localparam logic [63:0] VALID_T5 = 64'h22;
`else
  localparam logic [63:0] ERR_T5   = 64'h20;
  localparam logic [63:0] VALID_T5 = 64'h02;
`endif

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", nm, act, exp);
    end
  endtask

  function automatic bit mdl_en(input int j);
    if (mdl_sel[j] < 6) return 1'b1;
`ifdef XBAR_SEL_WRAP_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  function automatic int mdl_src(input int j);
    return (mdl_sel[j] < 6) ? mdl_sel[j] : mdl_sel[j] - 6;
  endfunction

  // Output monitor pops what the consumer takes; input side pushes what the producer hands over.
  always @(negedge clk) begin
    if (!rst) begin
      for (int j = 0; j < 6; j++) begin
        if (bus.out_valid_o[j] && bus.out_ready_i[j]) begin
          if (exp_q[j].size() == 0) begin
            checks++;
            errors++;
            $display("FAIL out%0d_unexpected: got beat %02h required no beat", j, bus.out_data_o[j]);
          end else begin
            mon_e = exp_q[j].pop_front();
            chk($sformatf("out%0d_data", j), 64'(bus.out_data_o[j]), 64'(mon_e));
          end
        end
      end
      for (int i = 0; i < 6; i++) begin
        if (bus.in_valid_i[i] && bus.in_ready_o[i]) begin
          for (int j = 0; j < 6; j++)
            if (mdl_en(j) && mdl_src(j) == i) exp_q[j].push_back(bus.in_data_i[i]);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input int i, input logic [7:0] d);
    bit done;
    done = 1'b0;
    bus.in_valid_i[i] = 1'b1;
    bus.in_data_i[i]  = d;
    for (int n = 0; n < 50 && !done; n++) begin
      @(negedge clk);
      if (bus.in_ready_o[i]) done = 1'b1;
      step();
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: in%0d got no ready required ready within 50 cycles", i);
    end
    bus.in_valid_i[i] = 1'b0;
  endtask

  task automatic cfg_pulse();
    for (int j = 0; j < 6; j++) bus.cfg_select_i[j] = 3'(tbl[j]);
    bus.cfg_valid_i = 1'b1;
    step();
    bus.cfg_valid_i = 1'b0;
  endtask

  task automatic mdl_load();
    for (int j = 0; j < 6; j++) mdl_sel[j] = tbl[j];
  endtask

  task automatic check_drained(input string nm);
    for (int j = 0; j < 6; j++) chk($sformatf("%s_q%0d_left", nm, j), 64'(exp_q[j].size()), 64'd0);
  endtask

  task automatic check_reset_state(input string nm);
    @(negedge clk);
    chk({nm, "_out_valid"}, 64'(bus.out_valid_o), 64'h0);
    chk({nm, "_out_data"}, 64'(bus.out_data_o), 64'h0);
    chk({nm, "_pending"}, 64'(bus.cfg_pending_o), 64'h0);
    chk({nm, "_sel_err"}, 64'(bus.sel_err_o), 64'h0);
    chk({nm, "_in_ready"}, 64'(bus.in_ready_o), 64'h3F);
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test required finish within 20000 cycles");
    $fatal(1, "watchdog");
  end

  initial begin
    clk = 1'b0;
    rst = 1'b1;
    checks = 0;
    errors = 0;
    bus.cfg_valid_i  = 1'b0;
    bus.cfg_select_i = '0;
    bus.in_valid_i   = '0;
    bus.in_data_i    = '0;
    bus.out_ready_i  = '1;
    for (int j = 0; j < 6; j++) mdl_sel[j] = j;
    repeat (2) step();
    check_reset_state("reset");
    rst = 1'b0;

    // Identity routing, single beat on input 3.
    send_beat(3, 8'hA5);
    @(negedge clk);
    chk("t1_out_valid", 64'(bus.out_valid_o), 64'h08);
    chk("t1_out_data3", 64'(bus.out_data_o[3]), 64'hA5);
    step();
    @(negedge clk);
    chk("t1_out_idle", 64'(bus.out_valid_o), 64'h00);
    step();

    // Broadcast input 2 to all outputs with a stalled listener.
    for (int j = 0; j < 6; j++) tbl[j] = 2;
    cfg_pulse();
    mdl_load();
    @(negedge clk);
    chk("t2_pending", 64'(bus.cfg_pending_o), 64'h1);
    chk("t2_ready_pending", 64'(bus.in_ready_o), 64'h00);
    step();
    @(negedge clk);
    chk("t2_committed", 64'(bus.cfg_pending_o), 64'h0);
    chk("t2_ready_bcast", 64'(bus.in_ready_o), 64'h04);
    step();
    send_beat(2, 8'h11);
    bus.out_ready_i[4] = 1'b0;
    bus.in_valid_i[2]  = 1'b1;
    bus.in_data_i[2]   = 8'h12;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      chk("t2_stall_ready", 64'(bus.in_ready_o[2]), 64'h0);
      chk("t2_stall_valid4", 64'(bus.out_valid_o[4]), 64'h1);
      chk("t2_stall_data4", 64'(bus.out_data_o[4]), 64'h11);
      step();
    end
    bus.out_ready_i[4] = 1'b1;
    for (int b = 8'h12; b <= 8'h1F; b++) send_beat(2, 8'(b));
    repeat (3) step();
    check_drained("t2");

    // Config while output 0 is held; second request while pending is ignored.
    tbl = '{1, 0, 3, 2, 4, 4};
    bus.out_ready_i[0] = 1'b0;
    send_beat(2, 8'h33);
    cfg_pulse();
    mdl_load();
    for (int j = 0; j < 6; j++) bus.cfg_select_i[j] = 3'd5;
    bus.cfg_valid_i   = 1'b1;
    bus.in_valid_i[1] = 1'b1;
    bus.in_data_i[1]  = 8'h44;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      chk("t3_pending", 64'(bus.cfg_pending_o), 64'h1);
      chk("t3_ready_blocked", 64'(bus.in_ready_o), 64'h00);
      step();
      bus.cfg_valid_i = 1'b0;
    end
    bus.out_ready_i[0] = 1'b1;
    @(negedge clk);
    chk("t3_pending_last", 64'(bus.cfg_pending_o), 64'h1);
    chk("t3_ready_last", 64'(bus.in_ready_o), 64'h00);
    step();
    @(negedge clk);
    chk("t3_committed", 64'(bus.cfg_pending_o), 64'h0);
    chk("t3_ready_new", 64'(bus.in_ready_o), 64'h1F);
    step();
    bus.in_valid_i[1] = 1'b0;
    @(negedge clk);
    chk("t3_route_valid", 64'(bus.out_valid_o), 64'h01);
    chk("t3_route_data0", 64'(bus.out_data_o[0]), 64'h44);
    step();
    send_beat(4, 8'h55);
    repeat (2) step();
    check_drained("t3");

    // Input 5 has no listener: backpressured indefinitely.
    bus.in_valid_i[5] = 1'b1;
    bus.in_data_i[5]  = 8'h66;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      chk("t4_ready5", 64'(bus.in_ready_o[5]), 64'h0);
      chk("t4_no_output", 64'(bus.out_valid_o), 64'h00);
      step();
    end
    bus.in_valid_i[5] = 1'b0;

    // Out-of-range select entry 7 on output 5.
    tbl = '{0, 1, 2, 3, 4, 7};
    cfg_pulse();
    mdl_load();
    step();
    @(negedge clk);
    chk("t5_committed", 64'(bus.cfg_pending_o), 64'h0);
    chk("t5_sel_err", 64'(bus.sel_err_o), ERR_T5);
    chk("t5_in_ready", 64'(bus.in_ready_o), 64'h1F);
    step();
    send_beat(1, 8'h77);
    @(negedge clk);
    chk("t5_out_valid", 64'(bus.out_valid_o), VALID_T5);
    step();
    repeat (2) step();
    check_drained("t5");

    // Reset with a config pending and beats in flight.
    bus.out_ready_i[0] = 1'b0;
    send_beat(0, 8'h88);
    for (int j = 0; j < 6; j++) tbl[j] = 3;
    bus.in_valid_i[3] = 1'b1;
    bus.in_data_i[3]  = 8'h99;
    cfg_pulse();
    rst = 1'b1;
    @(negedge clk);
    chk("t6_pending_before_rst", 64'(bus.cfg_pending_o), 64'h1);
    step();
    rst = 1'b0;
    bus.in_valid_i  = '0;
    bus.out_ready_i = '1;
    for (int j = 0; j < 6; j++) begin
      exp_q[j].delete();
      mdl_sel[j] = j;
    end
    check_reset_state("t6");
    send_beat(4, 8'hC3);
    @(negedge clk);
    chk("t6_identity_valid", 64'(bus.out_valid_o), 64'h10);
    step();
    repeat (2) step();
    check_drained("t6");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/xbar_stream.md
Name: xbar_stream

Overview:
- Registered, flow-controlled successor to the combinational crossbar.
- Routes NumIn valid/ready input streams to NumOut output streams, with independent input and output counts.
- Output j sources the input given by entry j of a select table. Several outputs may select one input (broadcast, fork semantics).
- The select table is reprogrammed through a staged config port that commits only when the datapath has drained. Sits between producer and consumer stages that need 1-cycle-registered, backpressured steering.

Parameters:
ElemWidth, 8, bits per data element
NumIn, 6, number of input streams (>=2)
NumOut, 6, number of output streams (>=1)
SelWidth, $clog2(NumIn), derived; width of each select entry

Ports:
clk_i  input  1  clock, all state on rising edge
rst_i  input  1  synchronous reset, active-high
cfg_valid_i  input  1  request to load a new select table
cfg_select_i  input  [NumOut][SelWidth]  new table; entry j = source for output j
cfg_pending_o  output  1  staged table waiting to commit
in_valid_i  input  [NumIn]  input stream valid
in_data_i  input  [NumIn][ElemWidth]  input stream data
in_ready_o  output  [NumIn]  input stream ready
out_valid_o  output  [NumOut]  output stream valid
out_data_o  output  [NumOut][ElemWidth]  output stream data (registered)
out_ready_i  input  [NumOut]  output stream ready
sel_err_o  output  [NumOut]  active entry j is unusable (out of range)

Behaviour:
- Reset (rst_i high at an edge):
  - sel_q[j] = j mod NumIn; out_valid_o = 0; out_data_o = 0; cfg_pending_o = 0.
  - Shadow table is discarded. Reset mid-transfer or mid-config drops all in-flight beats and any staged table.
- Source resolution for output j, from the active table sel_q: if sel_q[j] < NumIn, src_j = sel_q[j] and the output is enabled. Out-of-range handling is set by the optional feature.
- Output slot j is a single register.
  - can_acc_j = !out_valid_o[j] || out_ready_i[j].
- in_ready_o[i]:
  - 1 only when cfg_pending_o = 0, at least one enabled output has src_j = i, and can_acc_j = 1 for every enabled j with src_j = i.
  - An input with no enabled listener has in_ready_o = 0; it is backpressured, never dropped.
  - in_ready_o never depends on in_valid_i. It may depend combinationally on out_ready_i.
- Transfer: fire_i = in_valid_i[i] && in_ready_o[i]. At that edge every enabled output j with src_j = i loads in_data_i[i] and sets out_valid_o[j] = 1.
- Otherwise, if out_ready_i[j] = 1, out_valid_o[j] clears. out_data_o holds its last value while invalid.
- Latency: exactly 1 cycle, input fire at edge k makes data visible on out_data_o after edge k. Full throughput of 1 beat/cycle per input when consumers are always ready.
- Broadcast is all-or-nothing: a beat is taken only when every listener can accept it, and all listeners load it in the same cycle.
- Output valid/data are stable while valid && !ready.
- Config state machine, IDLE / PENDING:
  - IDLE: cfg_valid_i = 1 copies cfg_select_i into the shadow, then goes to PENDING (cfg_pending_o = 1 next cycle).
  - PENDING: cfg_valid_i is ignored and all in_ready_o are forced 0.
  - Commit condition: at the first edge where can_acc_j = 1 for every j, sel_q becomes the shadow and the state returns to IDLE.
  - The new table governs routing from the following cycle.
  - Minimum: cfg_valid_i in cycle k, pending in k+1, committed table in use in k+2.
- sel_err_o[j]: combinational from sel_q; is 1 only when entry j is out of range and disabled.

Optional Feature:
XBAR_SEL_WRAP_EN:
- Defined: an entry sel_q[j] >= NumIn resolves to src_j = sel_q[j] - NumIn. This is always < NumIn, so the output is enabled. sel_err_o is tied to 0.
- Undefined: an out-of-range entry disables output j. out_valid_o[j] stays 0 and the output is never a listener. sel_err_o[j] = 1.

Test Plan:
- Reset, NumIn=NumOut=6, all out_ready_i=1, in_valid_i[3]=1, data 0xA5 -> out_valid_o[3]=1 with 0xA5 one cycle later; no other output valid.
- Load table all entries = 2, in_data_i[2] = 0x11..0x1F on consecutive cycles, out_ready_i[4]=0 after the first beat -> in_ready_o[2] drops to 0. All six outputs show the same sequence once out_ready_i[4] returns. No beat is lost or duplicated.
- Hold out_valid_o[0]=1 with out_ready_i[0]=0, pulse cfg_valid_i -> cfg_pending_o=1 and all in_ready_o=0 until out_ready_i[0]=1. The commit then happens at that edge, and the new routing applies the next cycle. A second cfg_valid_i while pending is ignored.
- Input 5 with no output selecting it, in_valid_i[5]=1 -> in_ready_o[5]=0 indefinitely, with no output activity from it.
- Entry sel=7, NumIn=6:
  - Without the macro: sel_err_o[j]=1 and out_valid_o[j] stays 0.
  - With XBAR_SEL_WRAP_EN: sel_err_o[j]=0 and output j carries input 1.
- Assert rst_i in the cycle an input fires with cfg pending -> next cycle all out_valid_o=0, out_data_o=0, cfg_pending_o=0, identity table.
